// File: rtl/cpu_oci_pkg.sv
// Shared types and constants for the OCI debug memory master.
// FSM encoding, jdo field positions and address step.
package cpu_oci_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_DONE
  } oci_state_e;

  localparam int JDO_RD_BIT     = 35;
  localparam int JDO_PAYLOAD_HI = 34;
  localparam int JDO_PAYLOAD_LO = 3;
  localparam int ADDR_INC       = 4;

endpackage

// File: rtl/cpu_oci_mem_master_timeout.sv
// Saturating stall counter for debug bus transfers.
// o_expired flags the stall cycle that reaches the limit.
module cpu_oci_timeout #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expired
);

  localparam logic [15:0] LIM    = 16'(TIMEOUT_CYCLES);
  localparam logic [15:0] LIM_M1 = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_cnt;

  // count stall cycles, hold at the limit
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_count_en && (r_cnt != LIM)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_expired = i_count_en && (r_cnt == LIM_M1);

endmodule

// File: rtl/cpu_oci_mem_master.sv
// JTAG debug memory master: turns ocimem commands into
// single-beat Avalon-MM transfers and reports status back.
module cpu_oci_mem_master
  import cpu_oci_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] av_address,
  output logic              av_read,
  output logic              av_write,
  output logic [31:0]       av_writedata,
  output logic [3:0]        av_byteenable,
  input  logic [31:0]       av_readdata,
  input  logic              av_waitrequest,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              cmd_dropped
);

  oci_state_e        r_state;
  oci_state_e        w_next;
  logic [ADDR_W-1:0] r_mon_a;
  logic [31:0]       r_mon_d;
  logic [31:0]       r_wdata;
  logic              r_ready;
  logic              r_err;
  logic              r_drop;
  logic              r_inc;

  logic [31:0]       w_payload;
  logic [ADDR_W-1:0] w_new_addr;
  logic              w_rd_bit;
  logic              w_any_take;
  logic              w_strobe;
  logic              w_expired;
  logic              w_unused_jdo;

  assign w_payload  = jdo[JDO_PAYLOAD_HI:JDO_PAYLOAD_LO];
  assign w_rd_bit   = jdo[JDO_RD_BIT];
  assign w_new_addr = ADDR_W'(w_payload) & ~(ADDR_W'(3));
  assign w_unused_jdo = ^{jdo[37:36], jdo[2:0]};
  assign w_any_take = take_action_ocimem_a
                    | take_action_ocimem_b
                    | take_no_action_ocimem_a;
  assign w_strobe   = (r_state == S_RD) || (r_state == S_WR);

  cpu_oci_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk      (clk),
    .i_rst_n    (reset_n),
    .i_clear    (r_state == S_IDLE),
    .i_count_en (w_strobe && av_waitrequest),
    .o_expired  (w_expired)
  );

  // next-state: command priority b > a > no_action
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (take_action_ocimem_b) begin
          w_next = S_WR;
        end else if (take_action_ocimem_a) begin
          if (w_rd_bit) w_next = S_RD;
        end else if (take_no_action_ocimem_a) begin
          w_next = S_RD;
        end
      end
      S_RD, S_WR: begin
        if (!av_waitrequest || w_expired) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // state register plus monitor datapath
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_mon_a <= '0;
      r_mon_d <= '0;
      r_wdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_drop  <= 1'b0;
      r_inc   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_drop  <= (r_state != S_IDLE) && w_any_take;
      unique case (r_state)
        S_IDLE: begin
          if (take_action_ocimem_b) begin
            r_mon_d <= w_payload;
            r_wdata <= w_payload;
            r_inc   <= 1'b1;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
          end else if (take_action_ocimem_a) begin
            r_mon_a <= w_new_addr;
            r_inc   <= 1'b0;
            r_ready <= !w_rd_bit;
            r_err   <= 1'b0;
          end else if (take_no_action_ocimem_a) begin
            r_inc   <= 1'b1;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        S_RD: begin
          if (!av_waitrequest) begin
            r_mon_d <= av_readdata;
          end else if (w_expired) begin
            r_inc <= 1'b0;
            r_err <= 1'b1;
          end
        end
        S_WR: begin
          if (av_waitrequest && w_expired) begin
            r_inc <= 1'b0;
            r_err <= 1'b1;
          end
        end
        S_DONE: begin
          if (r_inc) r_mon_a <= r_mon_a + ADDR_W'(ADDR_INC);
          r_inc   <= 1'b0;
          r_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign av_read       = (r_state == S_RD);
  assign av_write      = (r_state == S_WR);
  assign av_address    = r_mon_a;
  assign av_writedata  = r_wdata;
  assign av_byteenable = w_strobe ? 4'hF : 4'h0;
  assign MonDReg       = r_mon_d;
  assign MonAReg       = r_mon_a;
  assign monitor_ready = r_ready;
  assign monitor_error = r_err;
  assign cmd_dropped   = r_drop;

endmodule

// File: tb/tb_cpu_oci_mem_master.sv
// Bench for cpu_oci_mem_master: directed plus random commands
// against a command-level model of monitor state.
module tb_cpu_oci_mem_master;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        take_a = 1'b0;
  logic        take_b = 1'b0;
  logic        take_n = 1'b0;
  logic [31:0] av_address;
  logic        av_read;
  logic        av_write;
  logic [31:0] av_writedata;
  logic [3:0]  av_byteenable;
  logic [31:0] av_readdata = '0;
  logic        av_waitrequest = 1'b0;
  logic [31:0] MonDReg;
  logic [31:0] MonAReg;
  logic        monitor_ready;
  logic        monitor_error;
  logic        cmd_dropped;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_a = '0;
  logic [31:0] m_d = '0;
  logic        m_err = 1'b0;

  always #5 clk = ~clk;

  cpu_oci_mem_master #(
    .TIMEOUT_CYCLES(TO),
    .ADDR_W(32)
  ) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_a),
    .take_action_ocimem_b    (take_b),
    .take_no_action_ocimem_a (take_n),
    .av_address              (av_address),
    .av_read                 (av_read),
    .av_write                (av_write),
    .av_writedata            (av_writedata),
    .av_byteenable           (av_byteenable),
    .av_readdata             (av_readdata),
    .av_waitrequest          (av_waitrequest),
    .MonDReg                 (MonDReg),
    .MonAReg                 (MonAReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .cmd_dropped             (cmd_dropped)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // issue one command and act as the slave until ready
  task automatic do_cmd(input logic ca, input logic cb,
                        input logic cn, input logic [37:0] j,
                        input int stalls, input logic [31:0] rd,
                        output int nstb, output logic [31:0] addr,
                        output logic [31:0] wd, output logic wrote,
                        output int lat, output logic drop,
                        output logic stable);
    nstb = 0; addr = '0; wd = '0; wrote = 1'b0;
    lat = -1; drop = 1'b0; stable = 1'b1;
    @(negedge clk);
    take_a = ca; take_b = cb; take_n = cn; jdo = j;
    @(negedge clk);
    take_a = 1'b0; take_b = 1'b0; take_n = 1'b0; jdo = '0;
    for (int i = 0; i < 64; i++) begin
      if (cmd_dropped) drop = 1'b1;
      if (av_read || av_write) begin
        if (nstb == 0) begin
          addr = av_address; wd = av_writedata; wrote = av_write;
        end else if (av_address !== addr) begin
          stable = 1'b0;
        end
        if (av_byteenable !== 4'hF) stable = 1'b0;
        av_waitrequest = (nstb < stalls);
        av_readdata = av_waitrequest ? $urandom : rd;
        nstb++;
      end else begin
        av_waitrequest = 1'b0;
        if (monitor_ready) begin
          lat = i;
          break;
        end
      end
      @(negedge clk);
    end
    av_waitrequest = 1'b0;
  endtask

  // kind 0 = load addr, 1 = write, 2 = read-next
  task automatic run(input int kind, input logic [31:0] pay,
                     input logic rdb, input int stalls,
                     input logic [31:0] rdat, input logic extra);
    logic [37:0] j;
    logic ca, cb, cn, timed;
    int nstb, lat, expn;
    logic [31:0] addr, wd;
    logic wrote, drop, stable;
    j  = {2'($urandom), rdb, pay, 3'($urandom)};
    ca = (kind == 0) || (extra && kind == 1);
    cb = (kind == 1);
    cn = (kind == 2) || (extra && kind != 2);
    do_cmd(ca, cb, cn, j, stalls, rdat,
           nstb, addr, wd, wrote, lat, drop, stable);
    timed = (stalls >= TO);
    if (kind == 0) m_a = pay & 32'hFFFF_FFFC;
    if (kind == 0 && !rdb) begin
      chk("load_nstb", 64'(nstb), 64'd0);
      chk("load_lat", 64'(lat), 64'd0);
      m_err = 1'b0;
    end else begin
      expn = timed ? TO : stalls + 1;
      chk("strobe_cycles", 64'(nstb), 64'(expn));
      chk("latency", 64'(lat), 64'(expn + 1));
      chk("bus_addr", 64'(addr), 64'(m_a));
      chk("bus_dir", 64'(wrote), 64'(kind == 1));
      chk("bus_stable", 64'(stable), 64'd1);
      if (kind == 1) begin
        chk("bus_wdata", 64'(wd), 64'(pay));
        m_d = pay;
      end else if (!timed) begin
        m_d = rdat;
      end
      if (kind != 0 && !timed) m_a = m_a + 32'd4;
      m_err = timed;
    end
    chk("MonAReg", 64'(MonAReg), 64'(m_a));
    chk("MonDReg", 64'(MonDReg), 64'(m_d));
    chk("ready", 64'(monitor_ready), 64'd1);
    chk("error", 64'(monitor_error), 64'(m_err));
    chk("no_drop", 64'(drop), 64'd0);
  endtask

  initial begin
    logic [31:0] d;
    int k;

    repeat (3) @(negedge clk);
    chk("rst_read", 64'(av_read), 64'd0);
    chk("rst_write", 64'(av_write), 64'd0);
    chk("rst_addr", 64'(av_address), 64'd0);
    chk("rst_wdata", 64'(av_writedata), 64'd0);
    chk("rst_mond", 64'(MonDReg), 64'd0);
    chk("rst_mona", 64'(MonAReg), 64'd0);
    chk("rst_ready", 64'(monitor_ready), 64'd0);
    chk("rst_err", 64'(monitor_error), 64'd0);
    chk("rst_drop", 64'(cmd_dropped), 64'd0);
    chk("rst_be", 64'(av_byteenable), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run(0, 32'h0000_1000, 1'b1, 0, 32'hDEAD_BEEF, 1'b0);

    run(0, 32'h0000_2000, 1'b0, 0, 32'h0, 1'b0);
    run(1, 32'h11, 1'b0, 2, 32'h0, 1'b0);
    run(1, 32'h22, 1'b0, 2, 32'h0, 1'b0);
    run(1, 32'h33, 1'b0, 2, 32'h0, 1'b0);
    chk("stream_end", 64'(MonAReg), 64'h200C);

    run(0, 32'hFFFF_FFFF, 1'b0, 0, 32'h0, 1'b0);
    run(2, 32'h0, 1'b0, 0, 32'hCAFE_0001, 1'b0);
    chk("wrap", 64'(MonAReg), 64'h0);

    run(2, 32'h0, 1'b0, 100, 32'h1234_5678, 1'b0);
    run(0, 32'h0000_0040, 1'b0, 0, 32'h0, 1'b0);

    run(1, 32'hA5A5_0000, 1'b0, 1, 32'h0, 1'b1);

    d = $urandom;
    @(negedge clk);
    take_b = 1'b1; jdo = {3'b000, d, 3'b000};
    @(negedge clk);
    take_b = 1'b0;
    chk("busy_wr", 64'(av_write), 64'd1);
    av_waitrequest = 1'b1;
    take_a = 1'b1; jdo = {3'b001, 32'h0BAD_0000, 3'b000};
    @(negedge clk);
    take_a = 1'b0; jdo = '0;
    chk("busy_drop", 64'(cmd_dropped), 64'd1);
    @(negedge clk);
    chk("busy_drop_once", 64'(cmd_dropped), 64'd0);
    av_waitrequest = 1'b0;
    k = 0;
    while (!monitor_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    m_d = d;
    m_a = m_a + 32'd4;
    chk("busy_ready", 64'(monitor_ready), 64'd1);
    chk("busy_mona", 64'(MonAReg), 64'(m_a));
    chk("busy_mond", 64'(MonDReg), 64'(m_d));

    for (int i = 0; i < 30; i++) begin
      int kind, st;
      kind = $urandom_range(0, 2);
      st = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 12)
                                       : $urandom_range(0, 4);
      run(kind, $urandom, 1'($urandom), st, $urandom,
          1'($urandom));
    end

    @(negedge clk);
    take_n = 1'b1;
    @(negedge clk);
    take_n = 1'b0;
    av_waitrequest = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_read", 64'(av_read), 64'd1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mr_read", 64'(av_read), 64'd0);
    chk("mr_mond", 64'(MonDReg), 64'd0);
    chk("mr_mona", 64'(MonAReg), 64'd0);
    chk("mr_ready", 64'(monitor_ready), 64'd0);
    reset_n = 1'b1;
    av_waitrequest = 1'b0;
    m_a = '0; m_d = '0; m_err = 1'b0;
    run(2, 32'h0, 1'b0, 0, 32'h5555_AAAA, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
